// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// freq_meter: gated edge-counting frequency meter for an asynchronous input.
// The result is in GATE_DIV Hz per LSB and saturates at 20'hFFFFF.
// Revision: 1.0
// ============================================================================
module freq_meter #(
  parameter int BASE_SPEED = 50000000,
  parameter int GATE_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig_in,
  output logic [19:0] freq,
  output logic        valid,
  output logic        overflow,
  output logic        no_signal
);

  localparam int               GATE_CYCLES = BASE_SPEED / GATE_DIV;
  localparam int               CNT_W       = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [31:0]      DIV_W       = 32'(GATE_DIV);
  localparam logic [31:0]      FREQ_MAX    = 32'h000F_FFFF;

  generate
    if ((GATE_DIV < 1) || ((BASE_SPEED % GATE_DIV) != 0) || (GATE_CYCLES < 4)) begin : g_bad_cfg
      $error("freq_meter: GATE_DIV must divide BASE_SPEED exactly and give at least 4 gate cycles");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic [CNT_W-1:0] gate_cnt;
  logic [31:0]      edge_cnt;
  logic [31:0]      total;
  logic [31:0]      product;
  logic             terminal;
  logic             arm_timeout;
  logic             gate_done;
  logic             report;

  // s1/s2 resolve metastability; s3 is history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise        = s2 & ~s3;
  assign terminal    = (gate_cnt == GATE_LAST);
  assign total       = edge_cnt + 32'(rise);
  assign product     = total * DIV_W;
  assign arm_timeout = (state == ARM) && !rise && terminal;
  assign gate_done   = (state == GATE) && terminal;
  assign report      = en && (arm_timeout || gate_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = ARM;
      ARM:     if (rise) state_nxt = GATE;
      // An empty gate leaves nothing to stay aligned to, so realign on the next edge
      GATE:    if (terminal && (total == 32'd0)) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  // gate_cnt doubles as the no-signal timer while waiting in ARM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (!en) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        ARM: begin
          edge_cnt <= '0;
          gate_cnt <= (rise || terminal) ? '0 : gate_cnt + CNT_W'(1);
        end
        GATE: begin
          if (terminal) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
          end else begin
            gate_cnt <= gate_cnt + CNT_W'(1);
            edge_cnt <= total;
          end
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

  // An ARM timeout has total == 0, so the same path reports freq 0 / no_signal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq      <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      valid <= report;
      if (report) begin
        if (product > FREQ_MAX) begin
          freq     <= 20'hFFFFF;
          overflow <= 1'b1;
        end else begin
          freq     <= product[19:0];
          overflow <= 1'b0;
        end
        no_signal <= (total == 32'd0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// tb_freq_meter: directed and random waveforms on two configurations, checked
// against a gate-window model computed from the recorded input samples.
module tb_freq_meter;

  localparam int A_SPEED = 1000;
  localparam int A_DIV   = 1;
  localparam int A_GATE  = A_SPEED / A_DIV;
  localparam int B_SPEED = 4194304;
  localparam int B_DIV   = 524288;
  localparam int B_GATE  = B_SPEED / B_DIV;
  localparam int MAXE    = 65536;

  typedef struct packed {
    logic [31:0] e;
    logic [19:0] f;
    logic        o;
    logic        n;
  } ev_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a  = 1'b0;
  logic        sig_a = 1'b0;
  logic        en_b  = 1'b0;
  logic        sig_b = 1'b0;
  logic [19:0] freq_a, freq_b;
  logic        valid_a, valid_b, ovf_a, ovf_b, nos_a, nos_b;

  ev_t qa[$];
  ev_t qb[$];
  ev_t exp_q[$];
  bit  va[MAXE];
  bit  vb[MAXE];
  int  edge_n   = 0;
  int  seg_e0   = 0;
  int  checks   = 0;
  int  failures = 0;

  freq_meter #(.BASE_SPEED(A_SPEED), .GATE_DIV(A_DIV)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .sig_in(sig_a),
    .freq(freq_a), .valid(valid_a), .overflow(ovf_a), .no_signal(nos_a)
  );

  freq_meter #(.BASE_SPEED(B_SPEED), .GATE_DIV(B_DIV)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .sig_in(sig_b),
    .freq(freq_b), .valid(valid_b), .overflow(ovf_b), .no_signal(nos_b)
  );

  always #5 clk = ~clk;

  // v[E] is the input value captured by the DUT's first flop at posedge E
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (edge_n + 1 < MAXE) begin
      va[edge_n + 1] <= sig_a;
      vb[edge_n + 1] <= sig_b;
    end
  end

  always @(negedge clk) begin
    if (valid_a) qa.push_back('{32'(edge_n), freq_a, ovf_a, nos_a});
    if (valid_b) qb.push_back('{32'(edge_n), freq_b, ovf_b, nos_b});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A rise acted on at posedge E was sampled two and three edges earlier
  function automatic bit rise_at(input int which, input int e);
    if (e < 3) return 1'b0;
    if (which == 1) return vb[e-2] && !vb[e-3];
    return va[e-2] && !va[e-3];
  endfunction

  // Walk gate windows of g edges: alignment on the first rise, timeouts when none
  task automatic predict(input int which, input int e0, input int eend);
    int     g;
    longint dv;
    int     ref_e;
    bit     gating;
    int     found;
    int     cnt;
    longint r;
    ev_t    ev;
    g      = (which == 1) ? B_GATE : A_GATE;
    dv     = (which == 1) ? B_DIV : A_DIV;
    ref_e  = e0;
    gating = 1'b0;
    exp_q.delete();
    while (ref_e + g <= eend) begin
      if (!gating) begin
        found = -1;
        for (int e = ref_e + 1; e <= ref_e + g; e++) begin
          if (found < 0 && rise_at(which, e)) found = e;
        end
        if (found < 0) begin
          ev = '{32'(ref_e + g), 20'd0, 1'b0, 1'b1};
          exp_q.push_back(ev);
          ref_e = ref_e + g;
        end else begin
          gating = 1'b1;
          ref_e  = found;
        end
      end else begin
        cnt = 0;
        for (int e = ref_e + 1; e <= ref_e + g; e++) cnt += int'(rise_at(which, e));
        r = longint'(cnt) * dv;
        ev.e = 32'(ref_e + g);
        ev.f = (r > 64'd1048575) ? 20'hFFFFF : r[19:0];
        ev.o = (r > 64'd1048575);
        ev.n = (cnt == 0);
        exp_q.push_back(ev);
        if (cnt == 0) gating = 1'b0;
        ref_e = ref_e + g;
      end
    end
  endtask

  task automatic compare(input int which, input string tag);
    ev_t got[$];
    if (which == 1) got = qb; else got = qa;
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_ev%0d_edge", tag, i), 64'(got[i].e), 64'(exp_q[i].e));
      chk($sformatf("%s_ev%0d_val", tag, i), 64'({got[i].f, got[i].o, got[i].n}),
          64'({exp_q[i].f, exp_q[i].o, exp_q[i].n}));
    end
  endtask

  task automatic wave(input int which, input int n, input int h, input bit rnd);
    int run;
    run = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      if (h > 0) begin
        if (run == 0) begin
          if (which == 1) sig_b = ~sig_b; else sig_a = ~sig_a;
          run = rnd ? int'($urandom_range(1, h)) : h;
        end
        run--;
      end
    end
  endtask

  task automatic quiet(input int which, input int n);
    @(posedge clk); #2;
    if (which == 1) sig_b = 1'b0; else sig_a = 1'b0;
    wave(which, n, 0, 1'b0);
  endtask

  task automatic start_seg(input int which);
    @(posedge clk); #2;
    if (which == 1) begin en_b = 1'b1; qb.delete(); end
    else begin en_a = 1'b1; qa.delete(); end
    seg_e0 = edge_n + 1;
  endtask

  task automatic end_seg(input int which, input string tag);
    int eend;
    eend = edge_n;
    if (which == 1) en_b = 1'b0; else en_a = 1'b0;
    @(negedge clk); #1;
    predict(which, seg_e0, eend);
    compare(which, tag);
  endtask

  initial begin
    int eend;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_freq", 64'(freq_a), 64'd0);
    chk("reset_valid", 64'(valid_a), 64'd0);
    chk("reset_ovf", 64'(ovf_a), 64'd0);
    chk("reset_nosig", 64'(nos_a), 64'd0);
    chk("reset_freq_b", 64'(freq_b), 64'd0);
    rst_n = 1'b1;

    // 100 Hz square wave, then a one-edge enable drop mid-gate
    start_seg(0);
    wave(0, 3500, 5, 1'b0);
    end_seg(0, "tone100");
    chk("tone100_n", 64'(qa.size()), 64'd3);
    foreach (qa[i]) chk("tone100_val", 64'({qa[i].f, qa[i].o, qa[i].n}), 64'({20'd100, 1'b0, 1'b0}));
    for (int i = 1; i < qa.size(); i++) chk("tone100_spacing", 64'(qa[i].e - qa[i-1].e), 64'd1000);

    start_seg(0);
    chk("endrop_hold_freq", 64'(freq_a), 64'd100);
    chk("endrop_no_valid", 64'(valid_a), 64'd0);
    wave(0, 2200, 5, 1'b0);
    end_seg(0, "rearm");
    chk("rearm_n", 64'(qa.size()), 64'd2);
    if (qa.size() > 0) chk("rearm_last", 64'(qa[qa.size()-1].f), 64'd100);

    // No signal, then the tone starts
    quiet(0, 5);
    start_seg(0);
    wave(0, 2500, 0, 1'b0);
    wave(0, 1600, 5, 1'b0);
    end_seg(0, "nosig");
    chk("nosig_n", 64'(qa.size()), 64'd3);
    if (qa.size() == 3) begin
      chk("nosig_first", 64'({qa[0].f, qa[0].o, qa[0].n}), 64'({20'd0, 1'b0, 1'b1}));
      chk("nosig_recover", 64'({qa[2].f, qa[2].o, qa[2].n}), 64'({20'd100, 1'b0, 1'b0}));
    end

    // Asynchronous reset between clock edges, mid-gate
    quiet(0, 5);
    start_seg(0);
    wave(0, 1600, 5, 1'b0);
    eend = edge_n;
    #1 rst_n = 1'b0;
    #1;
    chk("areset_freq", 64'(freq_a), 64'd0);
    chk("areset_valid", 64'(valid_a), 64'd0);
    chk("areset_ovf", 64'(ovf_a), 64'd0);
    chk("areset_nosig", 64'(nos_a), 64'd0);
    en_a  = 1'b0;
    sig_a = 1'b0;
    predict(0, seg_e0, eend);
    compare(0, "prereset");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    quiet(0, 5);
    start_seg(0);
    wave(0, 2200, 5, 1'b0);
    end_seg(0, "postreset");
    if (qa.size() > 0) chk("postreset_last", 64'(qa[qa.size()-1].f), 64'd100);
    else chk("postreset_any", 64'(qa.size()), 64'd2);

    // Random waveforms on the 1 Hz/LSB meter
    for (int k = 0; k < 3; k++) begin
      start_seg(0);
      for (int j = 0; j < 4; j++)
        wave(0, int'($urandom_range(200, 1200)), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
      end_seg(0, $sformatf("randA%0d", k));
    end

    // Short gate, large LSB: max rate saturates, 2 edges is just over full scale
    quiet(1, 5);
    start_seg(1);
    wave(1, 40, 1, 1'b0);
    end_seg(1, "fastB");
    chk("fastB_n", 64'(qb.size()), 64'd4);
    foreach (qb[i]) chk("fastB_val", 64'({qb[i].f, qb[i].o, qb[i].n}), 64'({20'hFFFFF, 1'b1, 1'b0}));

    quiet(1, 5);
    start_seg(1);
    wave(1, 60, 4, 1'b0);
    end_seg(1, "oneB");
    foreach (qb[i]) chk("oneB_val", 64'({qb[i].f, qb[i].o, qb[i].n}), 64'({20'd524288, 1'b0, 1'b0}));

    quiet(1, 5);
    start_seg(1);
    wave(1, 60, 2, 1'b0);
    end_seg(1, "twoB");
    foreach (qb[i]) chk("twoB_val", 64'({qb[i].f, qb[i].o, qb[i].n}), 64'({20'hFFFFF, 1'b1, 1'b0}));

    for (int k = 0; k < 6; k++) begin
      start_seg(1);
      for (int j = 0; j < 4; j++)
        wave(1, int'($urandom_range(10, 80)), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      end_seg(1, $sformatf("randB%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of an asynchronous square-wave input, in Hz, by gated edge counting.
- Produces a 20-bit `freq` code: the same Hz-per-LSB encoding the tone/clock-divider path consumes, so a generated tone can be measured and fed back.
- Runs continuously while enabled, with no dead time between gates, and pulses `valid` on each new result.
- Sits between external signal inputs (or internal generated tones) and the control/display logic.

Parameters:
- BASE_SPEED, 50000000, system clock frequency in Hz.
- GATE_DIV, 1, gates per second. Gate length is GATE_CYCLES = BASE_SPEED / GATE_DIV clock cycles; the result LSB weight is GATE_DIV Hz. Must divide BASE_SPEED exactly, and GATE_CYCLES must be ≥ 4.

Ports:
- clk  in  1  system clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  measurement enable; level-sensitive.
- sig_in  in  1  asynchronous signal under measurement.
- freq  out  20  last measured frequency in Hz, saturated at 20'hFFFFF.
- valid  out  1  one-cycle pulse when `freq` / `overflow` / `no_signal` update.
- overflow  out  1  last result saturated.
- no_signal  out  1  last gate saw no rising edge.

Behaviour:
- Reset (rst_n low, asynchronous): `freq` = 0, `valid` = 0, `overflow` = 0, `no_signal` = 0. Synchronizer flops = 0, counters = 0, FSM = IDLE.
- Input path:
  - `sig_in` → 2-flop synchronizer (s1, s2) → history flop s3.
  - Rising edge `rise` = s2 & ~s3.
  - `rise` is asserted 3 clk edges after a `sig_in` rise that meets setup. Max countable rate is BASE_SPEED/2 edges/s.
- FSM states:
  - IDLE: counters held at 0. If en=1, go to ARM.
  - ARM: wait for the first `rise` to align the gate.
    - On `rise`: edge_cnt = 0, gate_cnt = 0, go to GATE. The aligning edge itself is not counted; it is the period-0 reference.
    - If GATE_CYCLES cycles pass in ARM without `rise`: report freq = 0, no_signal = 1, overflow = 0, pulse `valid`, restart the ARM timer.
  - GATE: gate_cnt increments every cycle; edge_cnt (32-bit) increments on each `rise`.
    - Terminal cycle is gate_cnt == GATE_CYCLES-1. A `rise` on that cycle is included in the result.
    - On the terminal cycle: result = (edge_cnt + rise) * GATE_DIV, in 32-bit arithmetic. If result > 20'hFFFFF, freq = 20'hFFFFF and overflow = 1; else freq = result[19:0] and overflow = 0. Set no_signal = (edge_cnt + rise == 0).
    - Registered outputs and the one-cycle `valid` pulse appear on the clock edge that ends the terminal cycle.
    - The same edge sets gate_cnt = 0 and edge_cnt = 0, and the FSM stays in GATE: no dead time, and the next gate is not re-aligned.
    - If the gate result had zero edges, go to ARM instead of staying in GATE.
- en deasserted in any state: next state IDLE and counters cleared. Any in-progress gate is discarded with no `valid`. Outputs hold their last values.
- en reasserted: IDLE → ARM on the next cycle.
- rst_n asserted mid-gate: immediate clear per the reset clause; no `valid`.
- `valid` is never high for two consecutive cycles (GATE_CYCLES ≥ 4).
- Outputs hold between `valid` pulses.
- Accuracy: ±1 count (±GATE_DIV Hz) from gate/edge phase.

Test Plan:
1. BASE_SPEED = 1000, GATE_DIV = 1. en = 1; sig_in toggles every 5 clk (period 10). After alignment:
   - First `valid` reports freq = 100, overflow = 0, no_signal = 0.
   - Subsequent `valid` pulses arrive exactly 1000 cycles apart, each with freq = 100.
2. Same config, sig_in held 0 with en = 1: `valid` every 1000 cycles with freq = 0, no_signal = 1. Then start toggling every 5 clk: the next gate after the first rise reports freq = 100, no_signal = 0.
3. BASE_SPEED = 1000, GATE_DIV = 2000 (must first be rejected as an invalid config). Instead use BASE_SPEED = 4000, GATE_DIV = 2, gate 2000 cycles, sig_in toggling every 2 clk (500 edges):
   - Expected result is 1000 → freq = 1000.
   - Then set GATE_DIV = 4000/4 = 1000 (gate = 4 cycles). A toggle every clk gives result 2*1000 = 2000 → freq = 2000. A fast toggle must not produce a valid count beyond 2 edges.
4. Saturation: BASE_SPEED = 4194304, GATE_DIV = 2 (gate 2097152 cycles), sig_in toggling every clk → 1048576 edges × 2 > 20'hFFFFF. Expect freq = 20'hFFFFF, overflow = 1.
5. Drop en for 1 cycle at gate_cnt = 500 in scenario 1: no `valid` for that gate, freq holds at 100, FSM re-arms. The next `valid` arrives ≥ 1000 cycles after the re-align edge and reports freq = 100.
6. Assert rst_n = 0 asynchronously mid-gate, between clk edges: all outputs read 0 immediately. After release with en = 1, normal measurement resumes and reports 100.
